// File: rtl/instr_fetch.sv
// Instruction fetch stage: small writable instruction memory plus a program
// counter. Each instruction is held for as many cycles as the control unit
// spends on its class. Fetching stops on a zero-class instruction.
// Ports: clk, rst (sync, active-high), start, prog_we/prog_addr/prog_data
// (memory load port), instr, pc, fetch_strobe, busy, halted, retired.
module instr_fetch #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   prog_we,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_BITS-1:0]     pc,
  output logic                   fetch_strobe,
  output logic                   busy,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   retired
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    HALT
  } state_t;

  state_t state;
  logic [2:0] cnt;

  logic [INSTR_WIDTH-1:0] imem [2**PC_BITS];

  logic                   wr_en;
  logic [INSTR_WIDTH-1:0] word0;
  logic [PC_BITS-1:0]     pc_nxt;
  logic [INSTR_WIDTH-1:0] word_nxt;
  logic [2:0]             len0;
  logic [2:0]             len_nxt;

  // Hold length per class; 0 marks the halting class.
  function automatic logic [2:0] hold_len(
    input logic [1:0] cls
  );
    logic [2:0] l;
    l = 3'd0;
    unique case (1'b1)
      (cls == 2'b01): l = 3'd3;
      (cls == 2'b10): l = 3'd4;
      (cls == 2'b11): l = 3'd3;
      (cls == 2'b00): l = 3'd0;
      default:        l = 3'd0;
    endcase
    return l;
  endfunction

  assign wr_en = prog_we && (state != HOLD);

  // A write to address 0 in the start cycle must be seen by that fetch.
  assign word0 = (wr_en && prog_addr == '0) ? prog_data : imem[0];

  assign pc_nxt   = pc + 1'b1;
  assign word_nxt = imem[pc_nxt];

  assign len0    = hold_len(word0[INSTR_WIDTH-1 -: 2]);
  assign len_nxt = hold_len(word_nxt[INSTR_WIDTH-1 -: 2]);

  // Memory survives rst on purpose.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      imem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      instr        <= '0;
      pc           <= '0;
      fetch_strobe <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      retired      <= '0;
      cnt          <= '0;
    end else begin
      fetch_strobe <= 1'b0;
      unique case (state)
        IDLE, HALT: begin
          if (start) begin
            pc    <= '0;
            instr <= word0;
            if (len0 == 3'd0) begin
              state  <= HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
              cnt    <= '0;
            end else begin
              // Extra cycle covers the control unit leaving reset.
              cnt          <= len0 + 3'd1;
              state        <= HOLD;
              busy         <= 1'b1;
              halted       <= 1'b0;
              fetch_strobe <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (cnt == 3'd1) begin
            retired <= retired + 1'b1;
            pc      <= pc_nxt;
            instr   <= word_nxt;
            if (len_nxt == 3'd0) begin
              state  <= HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
              cnt    <= '0;
            end else begin
              cnt          <= len_nxt;
              fetch_strobe <= 1'b1;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: the stimulus side predicts the sequence
// of fetched words from a memory model; a negedge monitor checks them.
module tb_instr_fetch;

  localparam int IW = 20;
  localparam int PB = 5;
  localparam int CW = 8;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          prog_we;
  logic [PB-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic [IW-1:0] instr;
  logic [PB-1:0] pc;
  logic          fetch_strobe;
  logic          busy;
  logic          halted;
  logic [CW-1:0] retired;

  instr_fetch #(
    .INSTR_WIDTH(IW),
    .PC_BITS(PB),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .instr(instr),
    .pc(pc),
    .fetch_strobe(fetch_strobe),
    .busy(busy),
    .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          halt;
    int          pc;
    logic [IW-1:0] w;
    int          len;
    int          ret;
  } ev_t;

  ev_t           q[$];
  logic [IW-1:0] mem_m [DEPTH];
  int            ret_m;
  int            n_chk;
  int            n_fail;
  bit            active;
  ev_t           cur;
  int            hcnt;
  bit            halted_q;

  task automatic check(input string name, input longint act,
                       input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int len_of(input logic [IW-1:0] w);
    logic [1:0] c;
    c = w[IW-1:IW-2];
    if (c == 2'b00) return 0;
    if (c == 2'b10) return 4;
    return 3;
  endfunction

  // Predict the whole run: walk memory from 0 until a zero-class word.
  task automatic build(input int max_ev);
    int p;
    bit first;
    ev_t e;
    p = 0;
    first = 1;
    for (int k = 0; k < max_ev; k++) begin
      e.pc = p;
      e.w  = mem_m[p];
      if (len_of(e.w) == 0) begin
        e.halt = 1;
        e.len  = 0;
        e.ret  = ret_m;
        q.push_back(e);
        return;
      end
      e.halt = 0;
      e.len  = len_of(e.w) + (first ? 1 : 0);
      e.ret  = 0;
      first  = 0;
      q.push_back(e);
      ret_m = (ret_m + 1) % 256;
      p = (p + 1) % DEPTH;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      active = 0;
    end else if (fetch_strobe) begin
      if (active) check("hold_len", hcnt, cur.len);
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL strobe: got unexpected strobe pc=%0d", pc);
        active = 0;
      end else begin
        cur = q.pop_front();
        check("strobe_kind", cur.halt, 0);
        check("fetch_pc", pc, cur.pc);
        check("fetch_instr", instr, cur.w);
        check("fetch_busy", busy, 1);
        active = 1;
        hcnt = 1;
      end
    end else if (halted && !halted_q) begin
      if (active) check("hold_len_last", hcnt, cur.len);
      active = 0;
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL halt: got unexpected halt pc=%0d", pc);
      end else begin
        cur = q.pop_front();
        check("halt_kind", cur.halt, 1);
        check("halt_pc", pc, cur.pc);
        check("halt_instr", instr, cur.w);
        check("halt_retired", retired, cur.ret);
        check("halt_busy", busy, 0);
      end
    end else if (active) begin
      hcnt++;
      check("instr_stable", instr, cur.w);
      check("hold_busy", busy, 1);
    end
    halted_q = halted;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [IW-1:0] d, input bit ok);
    prog_we   = 1;
    prog_addr = a[PB-1:0];
    prog_data = d;
    if (ok) mem_m[a] = d;
    tick();
    prog_we = 0;
  endtask

  task automatic go(input bit we, input int a, input logic [IW-1:0] d,
                    input int max_ev);
    start = 1;
    if (we) begin
      prog_we   = 1;
      prog_addr = a[PB-1:0];
      prog_data = d;
      mem_m[a]  = d;
    end
    build(max_ev);
    tick();
    start   = 0;
    prog_we = 0;
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (halted && q.size() == 0 && !active) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL wait_halt: got timeout expected halt");
    q.delete();
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
    q.delete();
    ret_m = 0;
    check("rst_instr", instr, 0);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_retired", retired, 0);
    check("rst_strobe", fetch_strobe, 0);
  endtask

  function automatic logic [IW-1:0] rnd_word(input bit zero);
    logic [1:0] c;
    logic [IW-3:0] b;
    c = zero ? 2'b00 : 2'($urandom_range(1, 3));
    b = (IW-2)'($urandom);
    return {c, b};
  endfunction

  initial begin
    int n;
    bit ok;
    n_chk = 0;
    n_fail = 0;
    ret_m = 0;
    active = 0;
    halted_q = 0;
    rst = 1;
    start = 0;
    prog_we = 0;
    prog_addr = '0;
    prog_data = '0;
    tick();
    do_reset();

    // Zero-class word at address 0 halts straight from IDLE.
    wr(0, 20'h01234, 1);
    go(0, 0, '0, 40);
    wait_halt();

    // Single instruction.
    wr(0, 20'h5B000, 1);
    wr(1, 20'h00000, 1);
    go(0, 0, '0, 40);
    wait_halt();

    // Class lengths.
    wr(0, 20'h5B000, 1);
    wr(1, 20'h86140, 1);
    wr(2, 20'hC6140, 1);
    wr(3, 20'h00000, 1);
    go(0, 0, '0, 40);
    wait_halt();

    // Writes during HOLD are dropped; writes in HALT land.
    wr(0, 20'h5B000, 1);
    wr(1, 20'h86140, 1);
    wr(2, 20'h00000, 1);
    go(0, 0, '0, 40);
    tick();
    wr(1, 20'hFFFFF, 0);
    wait_halt();
    wr(1, 20'hFFFFF, 1);
    go(0, 0, '0, 40);
    wait_halt();

    // Write to address 0 in the start cycle is fetched.
    go(1, 0, 20'hC0ABC, 40);
    wait_halt();

    // Random programs.
    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) wr(i, rnd_word(0), 1);
      wr(n, rnd_word(1), 1);
      if ($urandom_range(0, 1) == 1) go(1, 0, rnd_word(0), 40);
      else go(0, 0, '0, 40);
      wait_halt();
    end

    // Reset in the second hold cycle of imem[1], then replay.
    wr(0, 20'h5B000, 1);
    wr(1, 20'h86140, 1);
    wr(2, 20'hC6140, 1);
    wr(3, 20'h00000, 1);
    go(0, 0, '0, 40);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (fetch_strobe && pc == 1) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("wait_pc1", ok, 1);
    tick();
    do_reset();
    go(0, 0, '0, 40);
    wait_halt();

    // Full memory of non-halting words: pc wraps back through 0.
    for (int i = 0; i < DEPTH; i++) wr(i, rnd_word(0), 1);
    go(0, 0, '0, DEPTH + 3);
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check("wrap_drained", ok, 1);
    check("wrap_busy", busy, 1);
    check("wrap_pc", pc, 2);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
